// File: rtl/management_tx_mac_if.sv
// management_tx_mac_if: upstream transmit bus carrying frame start and payload bytes
interface management_tx_mac_if;
  logic        start;
  logic        data_valid;
  logic [31:0] data;
  logic [3:0]  bytes_valid;
  modport master(output start, data_valid, data, bytes_valid);
  modport slave(input start, data_valid, data, bytes_valid);
endinterface

// File: rtl/management_tx_mac.sv
// management_tx_mac: GMII transmit MAC adding preamble, padding, FCS and inter-frame gap
module management_tx_mac #(
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12
) (
  input  logic               tx_clk,
  input  logic               tx_rst_n,
  input  logic               link_up,
  management_tx_mac_if.slave tx_bus,
  output logic               tx_ready,
  output logic [7:0]         gmii_txd,
  output logic               gmii_tx_en,
  output logic               gmii_tx_er
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAD  = 3'd3;
  localparam logic [2:0] S_FCS  = 3'd4;
  localparam logic [2:0] S_IFG  = 3'd5;
  logic [2:0]      state_q, state_d, pre_q, pre_d;
  logic [10:0]     cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      ifg_q, ifg_d;
  logic [31:0]     crc_q, crc_d;
  logic [6:0][7:0] dl_q, dl_d;
  logic [6:0]      dlv_q, dlv_d;
  logic            open_q, open_d, ready_q, ready_d, en_q, en_d, er_q, er_d;
  logic [7:0]      txd_q, txd_d;
  logic            use_data;
  logic [7:0]      byte_w;
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  assign use_data = state_q == S_DATA && dlv_q[6];
  assign byte_w   = use_data ? dl_q[6] : 8'h00;
  // Next-state: seven delay stages plus the output register give the eight-byte-time alignment
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ifg_d    = ifg_q;
    crc_d    = crc_q;
    dl_d     = {dl_q[5:0], tx_bus.data[7:0]};
    dlv_d    = {dlv_q[5:0], tx_bus.data_valid & open_q};
    open_d   = open_q & tx_bus.data_valid;
    ready_d  = 1'b0;
    en_d     = 1'b0;
    er_d     = 1'b0;
    txd_d    = 8'h00;
    if (state_q != S_IDLE && state_q != S_IFG && !link_up) begin
      state_d = S_IFG;
      ifg_d   = '0;
      er_d    = 1'b1;
      dl_d    = '0;
      dlv_d   = '0;
      open_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_d = link_up;
          if (tx_bus.start && link_up) begin
            state_d = S_PRE;
            pre_d   = 3'd1;
            cnt_d   = '0;
            crc_d   = '1;
            open_d  = 1'b1;
            ready_d = 1'b0;
            en_d    = 1'b1;
            txd_d   = 8'h55;
          end
        end
        S_PRE: begin
          en_d    = 1'b1;
          txd_d   = pre_q == 3'd7 ? 8'hD5 : 8'h55;
          pre_d   = pre_q + 3'd1;
          state_d = pre_q == 3'd7 ? S_DATA : S_PRE;
        end
        S_DATA, S_PAD: begin
          en_d = 1'b1;
          if (use_data || cnt_q < 11'(MIN_LEN)) begin
            txd_d   = byte_w;
            crc_d   = crc_next(crc_q, byte_w);
            cnt_d   = cnt_q == 11'h7FF ? cnt_q : cnt_q + 11'd1;
            state_d = use_data ? S_DATA : S_PAD;
          end else begin
            txd_d   = ~crc_q[7:0];
            idx_d   = 2'd1;
            state_d = S_FCS;
          end
        end
        S_FCS: begin
          en_d    = 1'b1;
          txd_d   = ~crc_q[{idx_q, 3'b000} +: 8];
          idx_d   = idx_q + 2'd1;
          ifg_d   = '0;
          state_d = idx_q == 2'd3 ? S_IFG : S_FCS;
        end
        S_IFG: begin
          ifg_d   = ifg_q + 8'd1;
          state_d = ifg_q == 8'(IFG_LEN - 1) ? S_IDLE : S_IFG;
          ready_d = ifg_q == 8'(IFG_LEN - 1) && link_up;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // State and registered outputs; reset truncates any frame without signalling an error
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ifg_q   <= '0;
      crc_q   <= '1;
      dl_q    <= '0;
      dlv_q   <= '0;
      open_q  <= 1'b0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      txd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ifg_q   <= ifg_d;
      crc_q   <= crc_d;
      dl_q    <= dl_d;
      dlv_q   <= dlv_d;
      open_q  <= open_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      er_q    <= er_d;
      txd_q   <= txd_d;
    end
  end
  assign tx_ready   = ready_q;
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign gmii_tx_er = er_q;
endmodule

// File: tb/tb_management_tx_mac.sv
// tb_management_tx_mac: scoreboard bench with a frame-level reference model
module tb_management_tx_mac;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic link = 1'b0;
  logic rdy, en, er, rdy9, en9, er9;
  logic [7:0] txd, txd9;
  management_tx_mac_if bus();
  management_tx_mac_if bus9();
  management_tx_mac dut (.tx_clk(clk), .tx_rst_n(rst_n), .link_up(link), .tx_bus(bus),
    .tx_ready(rdy), .gmii_txd(txd), .gmii_tx_en(en), .gmii_tx_er(er));
  management_tx_mac #(.MIN_LEN(9)) dut9 (.tx_clk(clk), .tx_rst_n(rst_n), .link_up(link), .tx_bus(bus9),
    .tx_ready(rdy9), .gmii_txd(txd9), .gmii_tx_en(en9), .gmii_tx_er(er9));
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] tab[256];
  logic [7:0] exp_b[$];
  int exp_len[$];
  bit exp_ab[$];
  logic [7:0] got[$];
  logic [7:0] cap9[$];
  bit prev_en = 0;
  bit rdy_in = 0;
  int gap = 1000;
  int last_gap = 0;
  int en_cnt = 0;
  int er9_cnt = 0;

  // Whole-frame model: preamble, payload, zero padding to the minimum, table-driven CRC-32 LSB first
  function automatic bq_t frame_of(input bq_t p, input int min_len);
    bq_t f;
    bq_t body;
    logic [31:0] c;
    body = p;
    c = 32'hFFFFFFFF;
    while (body.size() < min_len) body.push_back(8'h00);
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    foreach (body[i]) begin
      c = tab[c[7:0] ^ body[i]] ^ (c >> 8);
      f.push_back(body[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    return f;
  endfunction

  task automatic end_frame();
    int n;
    int mis;
    bit ab;
    logic [7:0] w[$];
    total++;
    if (exp_len.size() == 0) begin
      bad++;
      $display("FAIL unexpected_frame got_len=%0d want=no frame", got.size());
    end else begin
      n = exp_len.pop_front();
      ab = exp_ab.pop_front();
      for (int i = 0; i < n; i++) w.push_back(exp_b.pop_front());
      if (got.size() != n) begin
        bad++;
        $display("FAIL frame_len got=%0d want=%0d", got.size(), n);
      end
      total++;
      mis = -1;
      for (int i = 0; i < n && i < got.size(); i++) if (mis < 0 && got[i] !== w[i]) mis = i;
      if (mis >= 0) begin
        bad++;
        $display("FAIL frame_byte idx=%0d got=%02h want=%02h", mis, got[mis], w[mis]);
      end
      total++;
      if (er !== ab) begin
        bad++;
        $display("FAIL tx_er_at_end got=%b want=%b", er, ab);
      end
      total++;
      if (rdy_in) begin
        bad++;
        $display("FAIL ready_during_frame got=1 want=0");
      end
    end
    got.delete();
    rdy_in = 0;
  endtask

  // Monitor: collects every tx_en burst and checks it against the oldest expected frame
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      got.delete();
      exp_b.delete();
      exp_len.delete();
      exp_ab.delete();
      prev_en = 0;
      rdy_in = 0;
    end else begin
      if (en) begin
        if (!prev_en) last_gap = gap;
        got.push_back(txd);
        rdy_in = rdy_in | rdy;
        gap = 0;
        en_cnt++;
      end else begin
        if (prev_en) end_frame();
        else if (er) begin
          total++;
          bad++;
          $display("FAIL stray_tx_er got=1 want=0");
        end
        gap++;
      end
      prev_en = en;
    end
  end

  initial forever begin
    @(negedge clk);
    if (en9) cap9.push_back(txd9);
    if (er9) er9_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] want_v);
    total++;
    if (got_v !== want_v) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got_v, want_v);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (rdy !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (rdy !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got=%b want=1", rdy);
    end
  endtask

  // Issues one frame from the current negedge; drop_k>=0 lowers link_up in cycle N+drop_k
  task automatic send(input int len, input int drop_k, input bit junk);
    bq_t p;
    bq_t f;
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
    f = frame_of(p, 60);
    if (drop_k >= 0) while (f.size() > drop_k) void'(f.pop_back());
    foreach (f[i]) exp_b.push_back(f[i]);
    exp_len.push_back(f.size());
    exp_ab.push_back(drop_k >= 0);
    if (junk) begin
      bus.data_valid = 1'b1;
      bus.data = $urandom;
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.data_valid = 1'b0;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k == 1) check("ready_low_n1", 32'(rdy), 0);
      bus.start = 1'b0;
      bus.data_valid = k <= len;
      bus.data = $urandom;
      if (k <= len) bus.data[7:0] = p[k-1];
      if (k == drop_k) link = 1'b0;
    end
    if (junk) begin
      repeat (3) begin
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.start = $urandom_range(0, 1);
        bus.data = $urandom;
      end
      @(negedge clk);
      bus.data_valid = 1'b0;
      bus.start = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int n;
    logic [7:0] w9[$];
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = 32'(i);
      for (int b = 0; b < 8; b++) v = v[0] ? (v >> 1) ^ 32'hEDB88320 : v >> 1;
      tab[i] = v;
    end
    bus.start = 0; bus.data_valid = 0; bus.data = 0; bus.bytes_valid = 0;
    bus9.start = 0; bus9.data_valid = 0; bus9.data = 0; bus9.bytes_valid = 0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(rdy), 0);
    check("rst_en", 32'(en), 0);
    check("rst_er", 32'(er), 0);
    check("rst_txd", 32'(txd), 0);
    link = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(rdy), 1);

    // Known-answer frame on the MIN_LEN=9 instance
    @(negedge clk);
    bus9.start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus9.start = 1'b0;
      bus9.data_valid = k < 9;
      bus9.data = {24'hABCDEF, 8'h31 + 8'(k)};
    end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 7; i++) w9.push_back(8'h55);
    w9.push_back(8'hD5);
    for (int i = 0; i < 9; i++) w9.push_back(8'h31 + 8'(i));
    w9.push_back(8'h26); w9.push_back(8'h39); w9.push_back(8'hF4); w9.push_back(8'hCB);
    check("kat_len", 32'(cap9.size()), 21);
    n = -1;
    for (int i = 0; i < 21 && i < cap9.size(); i++) if (n < 0 && cap9[i] !== w9[i]) n = i;
    check("kat_first_bad_idx", 32'(n), 32'hFFFFFFFF);
    check("kat_tx_er", 32'(er9_cnt), 0);

    wait_ready();
    send(14, -1, 0);
    wait_ready();
    send(0, -1, 0);
    for (int i = 0; i < 6; i++) begin
      wait_ready();
      send($urandom_range(0, 100), -1, 1'($urandom_range(0, 1)));
    end

    // Start with link down must be dropped
    wait_ready();
    link = 1'b0;
    snap = en_cnt;
    bus.start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.data_valid = 1'b1;
      bus.data = $urandom;
    end
    @(negedge clk);
    bus.data_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("linkdown_start_en_cycles", 32'(en_cnt - snap), 0);
    check("linkdown_ready", 32'(rdy), 0);
    link = 1'b1;

    // Link drop at the 20th data byte
    wait_ready();
    send(40, 28, 0);
    repeat (30) @(negedge clk);
    check("abort_ready_held", 32'(rdy), 0);
    link = 1'b1;

    // Back-to-back long frames, the second beyond counter saturation
    wait_ready();
    send(1514, -1, 0);
    wait_ready();
    send(2100, -1, 0);
    check("b2b_gap", 32'(last_gap), 12);

    // Reset during FCS, then a clean frame
    wait_ready();
    send(64, -1, 0);
    n = 0;
    while (got.size() < 73 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1 rst_n = 1'b0;
    #1;
    check("midrst_en", 32'(en), 0);
    check("midrst_er", 32'(er), 0);
    check("midrst_txd", 32'(txd), 0);
    check("midrst_ready", 32'(rdy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", 32'(rdy), 1);
    send(30, -1, 0);
    wait_ready();
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_len.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/management_tx_mac.md
MANAGEMENT_TX_MAC -- requirements
Module: management_tx_mac

Interface
REQ-001 SHALL have parameter MIN_LEN, default 60, minimum frame length in bytes before FCS; shorter frames are zero-padded.
REQ-002 SHALL have parameter IFG_LEN, default 12, number of idle byte times enforced after the last FCS byte.
REQ-003 SHALL have port tx_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port tx_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port link_up, input, 1 bit: PHY link status, synchronous to tx_clk.
REQ-006 SHALL have port tx_bus, input, EthernetTxBus: start, data_valid, data[7:0] used; data[31:8] and bytes_valid are ignored.
REQ-007 SHALL have port tx_ready, output, 1 bit: high when a new frame may be started.
REQ-008 SHALL have port gmii_txd, output, 8 bits: GMII transmit data.
REQ-009 SHALL have port gmii_tx_en, output, 1 bit: GMII transmit enable.
REQ-010 SHALL have port gmii_tx_er, output, 1 bit: GMII transmit error.

Function
REQ-011 Upstream contract: start is a 1-cycle pulse in cycle N; payload bytes arrive with data_valid high on consecutive cycles from N+1; the first cycle with data_valid low ends the payload.
REQ-012 States SHALL be IDLE, PREAMBLE, DATA, PAD, FCS, IFG; all outputs registered.
REQ-013 IDLE: when start=1 and link_up=1, go to PREAMBLE. tx_ready SHALL fall in cycle N+1.
REQ-014 PREAMBLE: gmii_tx_en=1 from N+1; gmii_txd=0x55 for cycles N+1..N+7 and 0xD5 (SFD) at N+8; then go to DATA.
REQ-015 An 8-stage byte delay line (data plus valid) SHALL align input to output. The byte arriving at cycle N+k is driven on gmii_txd at N+k+8.
REQ-016 DATA: drive delayed bytes, count them with an 11-bit saturating byte counter, and fold each into the CRC. When the delayed valid drops, go to PAD if count < MIN_LEN, else go to FCS.
REQ-017 PAD: drive 0x00 (CRC-folded) until count = MIN_LEN, then go to FCS; a zero-length payload SHALL produce MIN_LEN pad bytes.
REQ-018 CRC SHALL be IEEE 802.3: polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement, computed byte-per-cycle.
REQ-019 FCS: emit 4 bytes, least-significant byte of the complemented CRC first, then go to IFG.
REQ-020 IFG: gmii_tx_en=0, gmii_txd=0x00 for IFG_LEN cycles, then go to IDLE.
REQ-021 tx_ready SHALL be 1 only in IDLE with link_up=1, registered.
REQ-022 A start received outside IDLE SHALL be ignored; a data_valid seen in IDLE without a preceding start SHALL be ignored.
REQ-023 If data_valid reasserts after the payload ended, those bytes SHALL be discarded.
REQ-024 If link_up falls in any state other than IDLE/IFG: next cycle gmii_tx_en=0, gmii_tx_er=1 for exactly one cycle, delay line cleared, go to IFG.
REQ-025 A start with link_up=0 SHALL be dropped; state stays IDLE.
REQ-026 gmii_tx_er SHALL be 0 except as in REQ-024.
REQ-027 Frames longer than 1514 payload bytes SHALL pass unmodified; the counter saturates at 2047 and does not wrap.

Reset
REQ-028 On tx_rst_n low, asynchronously: state=IDLE, tx_ready=0, gmii_tx_en=0, gmii_tx_er=0, gmii_txd=0x00, CRC=0xFFFFFFFF, counters=0, delay line valid bits=0.
REQ-029 After reset release, tx_ready SHALL rise on the first clock edge with link_up=1.
REQ-030 Reset asserted mid-frame SHALL truncate the frame immediately, with no tx_er.

Verification
REQ-031 With MIN_LEN=9, send the payload "123456789" (0x31..0x39) -> 7x0x55, 0xD5, 9 bytes, FCS 0x26 0x39 0xF4 0xCB; gmii_tx_en high for exactly 21 cycles.
REQ-032 Default parameters, 14-byte payload -> 14 data bytes + 46 zero bytes + 4 FCS bytes (matching the reference model), tx_en high 72 cycles, tx_ready low from N+1 until 12 idle cycles after tx_en falls.
REQ-033 Zero-length frame (start, no data_valid) -> 8 preamble bytes, 60 zero bytes, FCS 0x?? per model; no hang.
REQ-034 Drop link_up at the 20th data byte -> tx_en low next cycle, tx_er pulses 1 cycle, 12-cycle IFG, tx_ready stays 0 until link_up returns.
REQ-035 Back-to-back: 1514-byte frame, then start re-issued on the first cycle tx_ready=1 -> second preamble begins exactly 12 cycles after the first frame's last FCS byte.
REQ-036 Assert tx_rst_n low during FCS -> all outputs at reset values in the same cycle; the next frame after release is correct.
